kitt_tail_fader: RTL and testbench
==================================

KITT_TAIL_FADER -- requirements
Module: kitt_tail_fader

Interface
REQ-001 Parameter: DECAY_DIV, 100000, clock cycles per decay tick (10 ms at 10 MHz); legal range 2..2^20.
REQ-002 Parameter: PWM_BITS, 4, brightness and PWM resolution in bits; fixed at 4 for this release.
REQ-003 Port: clk  input  1  system clock (10 MHz); the block has one clock.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: ena  input  1  fader enable; low clears all brightness and holds all counters.
REQ-006 Port: led_in  input  8  one-hot or zero scan position from the scan core (LEDOUT); bit i high lights channel i.
REQ-007 Port: tail_sel  input  2  decay step per tick: 00=1, 01=2, 10=4, 11=8.
REQ-008 Port: oinv  input  1  inverts pwm_out for active-low LED boards.
REQ-009 Port: pwm_out  output  8  registered per-channel PWM drive.
REQ-010 Port: bright  output  32  debug view; bits 4i+3:4i hold the brightness of channel i.

Function
REQ-011 Each channel i SHALL hold a 4-bit brightness b[i] in the range 0..15.
REQ-012 A prescaler SHALL count 0..DECAY_DIV-1, wrap to 0, and assert a one-cycle tick while its count equals DECAY_DIV-1.
REQ-013 On each edge with ena=1 and led_in[i]=1, b[i] SHALL load 15.
REQ-014 On each edge with ena=1, led_in[i]=0 and tick=1, b[i] SHALL become max(b[i]-step, 0); the step is selected by tail_sel.
REQ-015 If led_in[i]=1 and tick=1 on the same edge, the load to 15 SHALL win; no decrement is applied.
REQ-016 Otherwise b[i] SHALL hold its value.
REQ-017 Decrement SHALL saturate at 0 and never wrap; for example b=3, step=4 gives 0.
REQ-018 A PWM counter SHALL be free-running and count 0..14, giving a 15-cycle period, then wrap to 0.
REQ-019 pwm_raw[i] SHALL equal (b[i] > pwm_cnt).
  - b=0 is always off.
  - b=15 is always on.
  - b=k is on for k of every 15 cycles.
REQ-020 pwm_out[i] SHALL be registered as pwm_raw[i] XOR oinv.
REQ-021 Latency: led_in[i] sampled high at edge N gives b[i]=15 after edge N and pwm_out[i] active after edge N+1.
REQ-022 oinv SHALL affect pwm_out from the next edge only; it SHALL NOT affect brightness state.
REQ-023 When ena=0 at an edge:
  - all b[i], the prescaler and pwm_cnt SHALL go to 0;
  - pwm_out SHALL register 8{oinv}, which means all LEDs are off.
REQ-024 When ena rises, the prescaler and pwm_cnt SHALL start from 0 on the first enabled edge.
REQ-025 tail_sel changes SHALL apply at the next tick with no glitch on the in-progress value.
REQ-026 A multi-hot led_in SHALL be legal; each set bit loads independently.
REQ-027 bright SHALL reflect the b registers combinationally, with no extra delay.

Reset
REQ-028 While rst=1, regardless of clk:
  - all b[i], the prescaler and pwm_cnt SHALL be 0;
  - pwm_out SHALL be 8'h00 and bright SHALL be 32'h0.
REQ-029 Reset asserted mid-fade SHALL discard all brightness at once; there is no partial state.
REQ-030 After rst deasserts, the first edge SHALL be treated as prescaler count 0.

Structure
REQ-031 Shared package kitt_pkg SHALL hold the following, and the scan core SHALL import the same package:
  - PWM_BITS, the PWM period constant (15) and BRIGHT_MAX (15);
  - the tail_sel step encoding table.
REQ-032 One sub-module, kitt_fade_channel, SHALL be instantiated 8 times.
  - It holds one b register and its compare with pwm_cnt.
  - The prescaler, pwm_cnt and tick are shared in the top level.
REQ-033 The design SHALL be fully synchronous to clk apart from the asynchronous rst, and SHALL contain no latches.

Verification (DECAY_DIV=4 unless noted)
REQ-034 Test: rst=1 for 3 cycles with random inputs; required: pwm_out=00, bright=0; after release with ena=1 and led_in=00, outputs stay 0 for 100 cycles.
REQ-035 Test: ena=1, tail_sel=00, led_in=01 for 1 cycle then 00; required: bright[3:0]=15, then decrements by 1 every 4 cycles and reaches 0 after 15 ticks (60 cycles), then stays 0.
REQ-036 Test: tail_sel=11, b=15 with led_in released; required: values 15, 7, 0 on successive ticks (saturation check).
REQ-037 Test: led_in[2]=1 held across a tick edge; required: b[2] stays 15, and pwm_out[2] stays 1 over a full 15-cycle period.
REQ-038 Test: b[0]=5 held (DECAY_DIV=1000); required: pwm_out[0] high for exactly 5 of every 15 cycles; with oinv=1, low for exactly 5.
REQ-039 Test: ena dropped mid-fade with b values nonzero; required: the next edge gives bright=0 and pwm_out=8{oinv}; rst asserted mid-fade gives the same with pwm_out=00 asynchronously.

Source files
------------

// File: rtl/kitt_pkg.sv
// Shared constants and tail-step encoding for the KITT scanner and tail fader.
package kitt_pkg;

    localparam int PWM_BITS   = 4;
    localparam int PWM_PERIOD = 15;
    localparam int N_CH       = 8;

    localparam logic [PWM_BITS-1:0] BRIGHT_MAX = 4'd15;
    localparam logic [PWM_BITS-1:0] PWM_LAST   = 4'(PWM_PERIOD - 1);

    typedef enum logic [1:0] {
        TAIL_1 = 2'b00,
        TAIL_2 = 2'b01,
        TAIL_4 = 2'b10,
        TAIL_8 = 2'b11
    } tail_sel_e;

    function automatic logic [PWM_BITS-1:0] tail_step(input tail_sel_e sel);
        case (sel)
            TAIL_1:  return 4'd1;
            TAIL_2:  return 4'd2;
            TAIL_4:  return 4'd4;
            TAIL_8:  return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/kitt_tail_fader_if.sv
// Control inputs and drive outputs of the tail fader, grouped for the top-level port.
interface kitt_tail_fader_if;
    import kitt_pkg::*;

    logic                  ena;
    logic [N_CH-1:0]       led_in;
    logic [1:0]            tail_sel;
    logic                  oinv;
    logic [N_CH-1:0]       pwm_out;
    logic [4*N_CH-1:0]     bright;

    modport master (
        output ena, led_in, tail_sel, oinv,
        input  pwm_out, bright
    );

    modport slave (
        input  ena, led_in, tail_sel, oinv,
        output pwm_out, bright
    );

endinterface

// File: rtl/kitt_fade_channel.sv
// One fader channel: a saturating brightness register and its PWM compare.
module kitt_fade_channel
    import kitt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                load,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] step,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] bright,
    output logic                pwm_raw
);

    logic [PWM_BITS-1:0] b;

    // Load beats decay when both land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b <= '0;
        end else if (!ena) begin
            b <= '0;
        end else if (load) begin
            b <= BRIGHT_MAX;
        end else if (tick) begin
            b <= (b > step) ? (b - step) : '0;
        end
    end

    assign bright  = b;
    assign pwm_raw = (b > pwm_cnt);

endmodule

// File: rtl/kitt_tail_fader.sv
// Eight-channel afterglow fader: shared decay prescaler and PWM counter, per-channel faders.
module kitt_tail_fader #(
    parameter int DECAY_DIV = 100000,
    parameter int PWM_BITS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    kitt_tail_fader_if.slave  bus
);
    import kitt_pkg::*;

    localparam int                PRE_W    = $clog2(DECAY_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DECAY_DIV - 1);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic [PWM_BITS-1:0] step;
    logic [N_CH-1:0]     pwm_raw;
    logic [N_CH-1:0]     pwm_q;
    logic [4*N_CH-1:0]   bright_w;

    assign tick = (pre_cnt == PRE_LAST);
    assign step = tail_step(tail_sel_e'(bus.tail_sel));

    // Disabling parks both counters at zero so re-enable starts a fresh period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            pwm_q   <= '0;
        end else if (!bus.ena) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            pwm_q   <= {N_CH{bus.oinv}};
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
            pwm_q   <= pwm_raw ^ {N_CH{bus.oinv}};
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        kitt_fade_channel u_ch (
            .clk     (clk),
            .rst     (rst),
            .ena     (bus.ena),
            .load    (bus.led_in[i]),
            .tick    (tick),
            .step    (step),
            .pwm_cnt (pwm_cnt),
            .bright  (bright_w[4*i +: 4]),
            .pwm_raw (pwm_raw[i])
        );
    end

    assign bus.pwm_out = pwm_q;
    assign bus.bright  = bright_w;

endmodule

// File: tb/tb_kitt_tail_fader.sv
// Scoreboard bench: two faders (fast and slow decay) share stimulus and are checked against a model.
module tb_kitt_tail_fader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #50 clk = ~clk;

    kitt_tail_fader_if bus0 ();
    kitt_tail_fader_if bus1 ();

    assign bus1.ena      = bus0.ena;
    assign bus1.led_in   = bus0.led_in;
    assign bus1.tail_sel = bus0.tail_sel;
    assign bus1.oinv     = bus0.oinv;

    kitt_tail_fader #(.DECAY_DIV(4))    dut0 (.clk(clk), .rst(rst), .bus(bus0));
    kitt_tail_fader #(.DECAY_DIV(1000)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: brightness per channel, decay phase, PWM phase, registered drive.
    int         mb   [2][8];
    int         mpre [2];
    int         mpc  [2];
    logic [7:0] mpo  [2];
    logic [39:0] q0 [$];
    logic [39:0] q1 [$];

    function automatic int div_of(input int d);
        return (d == 0) ? 4 : 1000;
    endfunction

    function automatic logic [31:0] pack_b(input int d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'(mb[d][i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) mb[d][i] = 0;
            mpre[d] = 0;
            mpc[d]  = 0;
            mpo[d]  = 8'h00;
        end
    endtask

    task automatic model_edge();
        bit tk;
        int stp;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) mb[d][i] = 0;
                mpre[d] = 0;
                mpc[d]  = 0;
                mpo[d]  = 8'h00;
            end else if (!bus0.ena) begin
                for (int i = 0; i < 8; i++) mb[d][i] = 0;
                mpre[d] = 0;
                mpc[d]  = 0;
                mpo[d]  = {8{bus0.oinv}};
            end else begin
                tk  = (mpre[d] == div_of(d) - 1);
                stp = 1 << bus0.tail_sel;
                for (int i = 0; i < 8; i++) begin
                    mpo[d][i] = (mb[d][i] > mpc[d]) ^ bus0.oinv;
                    if (bus0.led_in[i])
                        mb[d][i] = 15;
                    else if (tk)
                        mb[d][i] = (mb[d][i] > stp) ? mb[d][i] - stp : 0;
                end
                mpre[d] = (mpre[d] + 1) % div_of(d);
                mpc[d]  = (mpc[d] + 1) % 15;
            end
        end
        q0.push_back({mpo[0], pack_b(0)});
        q1.push_back({mpo[1], pack_b(1)});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    // Monitor: every clock the DUTs present a fresh output word.
    always @(negedge clk) begin
        logic [39:0] e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("dut0 pwm_out", 32'(bus0.pwm_out), 32'(e[39:32]));
            check("dut0 bright", bus0.bright, e[31:0]);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("dut1 pwm_out", 32'(bus1.pwm_out), 32'(e[39:32]));
            check("dut1 bright", bus1.bright, e[31:0]);
        end
    end

    task automatic cyc(input logic e, input logic [7:0] l, input logic [1:0] ts, input logic oi);
        bus0.ena      = e;
        bus0.led_in   = l;
        bus0.tail_sel = ts;
        bus0.oinv     = oi;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cyc_rand();
        cyc(1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
    endtask

    initial begin
        int cnt;
        int budget;
        bus0.ena = 1'b0; bus0.led_in = 8'h00; bus0.tail_sel = 2'b00; bus0.oinv = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #9;
        check("reset pwm_out", 32'(bus0.pwm_out), 32'h0);
        check("reset bright", bus0.bright, 32'h0);

        // Reset held with random inputs
        @(negedge clk);
        repeat (3) cyc_rand();
        rst = 1'b0;

        // Idle after release
        repeat (100) cyc(1'b1, 8'h00, 2'b00, 1'b0);

        // Single-step tail on channel 0
        cyc(1'b1, 8'h01, 2'b00, 1'b0);
        check("load ch0", 32'(bus0.bright[3:0]), 32'd15);
        repeat (70) cyc(1'b1, 8'h00, 2'b00, 1'b0);
        check("tail1 end", 32'(bus0.bright[3:0]), 32'd0);

        // Step 8 saturation
        cyc(1'b1, 8'h01, 2'b11, 1'b0);
        repeat (12) cyc(1'b1, 8'h00, 2'b11, 1'b0);
        check("tail8 end", 32'(bus0.bright[3:0]), 32'd0);

        // led_in[2] held across ticks: fully on
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 8'h04, 2'($urandom), 1'b0);
            if (k >= 5 && bus0.pwm_out[2]) cnt++;
        end
        check("held ch2 on count", 32'(cnt), 32'd15);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom % 16) != 0,
                (($urandom % 4) == 0) ? 8'($urandom) : 8'h00,
                2'($urandom), 1'($urandom));
        end

        // ena dropped mid-fade
        cyc(1'b1, 8'hff, 2'b00, 1'b0);
        repeat (3) cyc(1'b1, 8'h00, 2'b00, 1'b0);
        cyc(1'b0, 8'h00, 2'b00, 1'b1);
        check("ena drop bright", bus0.bright, 32'h0);
        check("ena drop pwm_out", 32'(bus0.pwm_out), 32'hff);

        // Asynchronous reset mid-fade
        cyc(1'b1, 8'hff, 2'b01, 1'b1);
        repeat (5) cyc(1'b1, 8'h00, 2'b01, 1'b1);
        #10 rst = 1'b1;
        #1;
        check("async rst dut0 pwm_out", 32'(bus0.pwm_out), 32'h0);
        check("async rst dut0 bright", bus0.bright, 32'h0);
        check("async rst dut1 bright", bus1.bright, 32'h0);
        model_reset();
        @(negedge clk);
        repeat (2) cyc_rand();
        rst = 1'b0;

        // Duty cycle at b=5 on the slow fader: 15 -> 7 (step 8) -> 5 (step 2)
        cyc(1'b0, 8'h00, 2'b00, 1'b0);
        cyc(1'b1, 8'h01, 2'b11, 1'b0);
        budget = 0;
        while (mb[1][0] != 7 && budget < 3000) begin
            cyc(1'b1, 8'h00, 2'b11, 1'b0);
            budget++;
        end
        if (budget >= 3000) timeout_fail("fade to 7");
        budget = 0;
        while (mb[1][0] != 5 && budget < 3000) begin
            cyc(1'b1, 8'h00, 2'b01, 1'b0);
            budget++;
        end
        if (budget >= 3000) timeout_fail("fade to 5");
        check("dut1 b0 at 5", 32'(bus1.bright[3:0]), 32'd5);
        cyc(1'b1, 8'h00, 2'b00, 1'b0);
        cnt = 0;
        repeat (15) begin
            cyc(1'b1, 8'h00, 2'b00, 1'b0);
            if (bus1.pwm_out[0]) cnt++;
        end
        check("duty 5/15 high", 32'(cnt), 32'd5);
        cyc(1'b1, 8'h00, 2'b00, 1'b1);
        cnt = 0;
        repeat (15) begin
            cyc(1'b1, 8'h00, 2'b00, 1'b1);
            if (!bus1.pwm_out[0]) cnt++;
        end
        check("duty 5/15 low inv", 32'(cnt), 32'd5);

        #20;
        if (q0.size() != 0 || q1.size() != 0) timeout_fail("scoreboard drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
